// File: rtl/twpm_wb_pkg.sv
// Shared constants for the TwPM Wishbone decoder: region codes, FSM states,
// error-cause codes and the read value returned on error responses.
package twpm_wb_pkg;

    localparam logic [3:0] REGION_REGS = 4'hF;
    localparam logic [3:0] REGION_DDR3 = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] ERR_CAUSE_NONE     = 2'd0;
    localparam logic [1:0] ERR_CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CAUSE_SLAVE    = 2'd3;

    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;

    function automatic logic region_mapped(input logic [3:0] region);
        return (region == REGION_REGS) || (region == REGION_DDR3);
    endfunction

endpackage

// File: rtl/twpm_wb_timeout.sv
// Busy-cycle counter for the Wishbone decoder; expire_o is high in the
// TIMEOUT_CYCLES-th enabled cycle after a clear.
module twpm_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TMO_W          = 9
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TMO_W-1:0] cnt;

    assign expire_o = (cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Saturate at expiry so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            cnt <= '0;
        else if (clr_i)
            cnt <= '0;
        else if (en_i && !expire_o)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/twpm_wb_decoder.sv
// Wishbone address decoder / response stage between NEORV32 and the TwPM slaves.
// Optional error log enabled by defining TWPM_WB_ERR_LOG_EN.
module twpm_wb_decoder
    import twpm_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TMO_W          = 9,
    parameter logic [31:0] DEFAULT_RD     = DEFAULT_READ_VALUE
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] m_adr_i,
    input  logic        m_we_i,
    input  logic        m_stb_i,
    input  logic        m_cyc_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack_o,
    output logic        m_err_o,
    output logic        s0_stb_o,
    input  logic        s0_ack_i,
    input  logic [31:0] s0_dat_i,
    output logic        s1_stb_o,
    input  logic        s1_ack_i,
    input  logic        s1_err_i,
    input  logic [31:0] s1_dat_i,
    output logic [31:0] err_adr_o,
    output logic [1:0]  err_cause_o,
    input  logic        err_clr_i
);

    state_e      state;
    logic        tgt;          // 0: register/RAM slave, 1: DDR3 slave
    logic        req, mapped, expire;
    logic        slv_ack, slv_err, err_set;
    logic [1:0]  err_code;
    logic [31:0] slv_dat;
    logic        unused_in;

    assign req      = m_cyc_i & m_stb_i;
    assign mapped   = region_mapped(m_adr_i[31:28]);
    assign slv_ack  = tgt ? s1_ack_i : s0_ack_i;
    assign slv_err  = tgt & s1_err_i;
    assign slv_dat  = tgt ? s1_dat_i : s0_dat_i;
    assign s0_stb_o = (state == ST_BUSY) & ~tgt & req;
    assign s1_stb_o = (state == ST_BUSY) &  tgt & req;

    twpm_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_tmo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (state != ST_BUSY),
        .en_i     (state == ST_BUSY),
        .expire_o (expire)
    );

    // Slave error beats a simultaneous ack; an ack beats timeout expiry.
    always_comb begin
        err_set  = 1'b0;
        err_code = ERR_CAUSE_NONE;
        case (state)
            ST_IDLE: if (req && !mapped) begin
                err_set  = 1'b1;
                err_code = ERR_CAUSE_UNMAPPED;
            end
            ST_BUSY: if (m_cyc_i) begin
                if (slv_err) begin
                    err_set  = 1'b1;
                    err_code = ERR_CAUSE_SLAVE;
                end else if (!slv_ack && expire) begin
                    err_set  = 1'b1;
                    err_code = ERR_CAUSE_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ST_IDLE;
            tgt     <= 1'b0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            case (state)
                ST_IDLE: if (req) begin
                    tgt <= (m_adr_i[31:28] == REGION_DDR3);
                    if (err_set) begin
                        state   <= ST_RESP;
                        m_err_o <= 1'b1;
                        m_dat_o <= DEFAULT_RD;
                    end else begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (err_set) begin
                        state   <= ST_RESP;
                        m_err_o <= 1'b1;
                        m_dat_o <= DEFAULT_RD;
                    end else if (slv_ack) begin
                        state   <= ST_RESP;
                        m_ack_o <= 1'b1;
                        m_dat_o <= slv_dat;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TWPM_WB_ERR_LOG_EN
    // First error is sticky; a clear coinciding with a new error logs the new one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_adr_o   <= '0;
            err_cause_o <= ERR_CAUSE_NONE;
        end else if (err_set && (err_cause_o == ERR_CAUSE_NONE || err_clr_i)) begin
            err_adr_o   <= m_adr_i;
            err_cause_o <= err_code;
        end else if (err_clr_i) begin
            err_adr_o   <= '0;
            err_cause_o <= ERR_CAUSE_NONE;
        end
    end
    assign unused_in = m_we_i;
`else
    assign err_adr_o   = '0;
    assign err_cause_o = ERR_CAUSE_NONE;
    assign unused_in   = ^{m_we_i, err_clr_i, err_code, m_adr_i[27:0]};
`endif

endmodule

// File: tb/tb_twpm_wb_decoder.sv
// Directed bench for twpm_wb_decoder: one default instance and one with an
// 8-cycle timeout, driven by a vector table plus hand-written corner sequences.
module tb_twpm_wb_decoder;

`ifdef TWPM_WB_ERR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] m_adr_i;
    logic        m_we_i, m_stb_i, cyc_a, cyc_b;
    logic        s0_ack_i, s1_ack_i, s1_err_i, err_clr_i;
    logic [31:0] s0_dat_i, s1_dat_i;

    logic [31:0] a_dat, b_dat, a_eadr, b_eadr;
    logic        a_ack, b_ack, a_err, b_err, a_s0, b_s0, a_s1, b_s1;
    logic [1:0]  a_ec, b_ec;

    logic        sel;      // 0: default instance, 1: 8-cycle-timeout instance
    logic [31:0] o_dat, o_eadr;
    logic        o_ack, o_err, o_s0, o_s1;
    logic [1:0]  o_ec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    twpm_wb_decoder dut_a (
        .clk_i(clk_i), .rstn_i(rstn_i), .m_adr_i(m_adr_i), .m_we_i(m_we_i),
        .m_stb_i(m_stb_i), .m_cyc_i(cyc_a), .m_dat_o(a_dat), .m_ack_o(a_ack),
        .m_err_o(a_err), .s0_stb_o(a_s0), .s0_ack_i(s0_ack_i), .s0_dat_i(s0_dat_i),
        .s1_stb_o(a_s1), .s1_ack_i(s1_ack_i), .s1_err_i(s1_err_i), .s1_dat_i(s1_dat_i),
        .err_adr_o(a_eadr), .err_cause_o(a_ec), .err_clr_i(err_clr_i)
    );

    twpm_wb_decoder #(.TIMEOUT_CYCLES(8), .TMO_W(4)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .m_adr_i(m_adr_i), .m_we_i(m_we_i),
        .m_stb_i(m_stb_i), .m_cyc_i(cyc_b), .m_dat_o(b_dat), .m_ack_o(b_ack),
        .m_err_o(b_err), .s0_stb_o(b_s0), .s0_ack_i(s0_ack_i), .s0_dat_i(s0_dat_i),
        .s1_stb_o(b_s1), .s1_ack_i(s1_ack_i), .s1_err_i(s1_err_i), .s1_dat_i(s1_dat_i),
        .err_adr_o(b_eadr), .err_cause_o(b_ec), .err_clr_i(err_clr_i)
    );

    assign o_dat  = sel ? b_dat  : a_dat;
    assign o_ack  = sel ? b_ack  : a_ack;
    assign o_err  = sel ? b_err  : a_err;
    assign o_s0   = sel ? b_s0   : a_s0;
    assign o_s1   = sel ? b_s1   : a_s1;
    assign o_eadr = sel ? b_eadr : a_eadr;
    assign o_ec   = sel ? b_ec   : a_ec;

    // Cycle 0 is the IDLE cycle in which the request is first presented.
    typedef struct {
        logic [31:0] adr;
        bit          b8;
        bit          clr;
        bit          slv;
        int          ack_at;
        int          err_at;
        logic [31:0] s0_dat;
        logic [31:0] s1_dat;
        int          exp_stb;   // 0 none, 1 s0, 2 s1
        int          exp_cyc;
        bit          exp_ack;
        logic [31:0] exp_dat;
        logic [1:0]  exp_cause;
        logic [31:0] exp_eadr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cyc(input logic v);
        cyc_a   = v & ~sel;
        cyc_b   = v & sel;
        m_stb_i = v;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int resp_cyc, n_resp, stb_bad, both;
        logic got_ack, got_err;
        logic [31:0] got_dat;
        string tag;
        tag = $sformatf("v%0d", idx);
        resp_cyc = -1; n_resp = 0; stb_bad = 0; both = 0;
        got_ack = 0; got_err = 0; got_dat = '0;
        sel = v.b8;
        if (v.clr) begin
            err_clr_i = 1'b1;
            tick();
            err_clr_i = 1'b0;
        end
        m_adr_i  = v.adr;
        s0_dat_i = v.s0_dat;
        s1_dat_i = v.s1_dat;
        set_cyc(1'b1);
        for (int c = 0; c < v.exp_cyc + 3; c++) begin
            s0_ack_i = !v.slv && (c == v.ack_at);
            s1_ack_i =  v.slv && (c == v.ack_at);
            s1_err_i = (c == v.err_at);
            @(negedge clk_i);
            if (o_s0 && v.exp_stb != 1) stb_bad++;
            if (o_s1 && v.exp_stb != 2) stb_bad++;
            if (o_ack && o_err) both++;
            if (o_ack || o_err) begin
                n_resp++;
                if (resp_cyc < 0) begin
                    resp_cyc = c;
                    got_ack  = o_ack;
                    got_err  = o_err;
                    got_dat  = o_dat;
                    set_cyc(1'b0);
                end
            end
            tick();
        end
        set_cyc(1'b0);
        s0_ack_i = 0; s1_ack_i = 0; s1_err_i = 0;
        chk({tag, " resp_cycle"}, resp_cyc, v.exp_cyc);
        chk({tag, " resp_count"}, n_resp, 1);
        chk({tag, " ack"}, {31'd0, got_ack}, {31'd0, v.exp_ack});
        chk({tag, " err"}, {31'd0, got_err}, {31'd0, !v.exp_ack});
        chk({tag, " both"}, both, 0);
        chk({tag, " dat"}, got_dat, v.exp_dat);
        chk({tag, " stray_stb"}, stb_bad, 0);
        chk({tag, " err_cause"}, {30'd0, o_ec}, LOG ? {30'd0, v.exp_cause} : 32'd0);
        chk({tag, " err_adr"}, o_eadr, LOG ? v.exp_eadr : 32'd0);
    endtask

    initial begin
        int nr;
        rstn_i = 0; m_adr_i = '0; m_we_i = 0; sel = 0; m_stb_i = 0; cyc_a = 0; cyc_b = 0;
        s0_ack_i = 0; s1_ack_i = 0; s1_err_i = 0; err_clr_i = 0;
        s0_dat_i = '0; s1_dat_i = '0;

        //          adr           b8 clr slv ack err s0_dat        s1_dat        stb cyc ack exp_dat       cause eadr
        vecs[0]  = '{32'hF0000004, 0, 1, 0,  3, -1, 32'd5,        32'd0,        1,  4,  1, 32'd5,        2'd0, 32'h0};
        vecs[1]  = '{32'h90000000, 0, 1, 1, 11, -1, 32'd0,        32'hDEADBEEF, 2, 12,  1, 32'hDEADBEEF, 2'd0, 32'h0};
        vecs[2]  = '{32'h30000000, 0, 1, 0, -1, -1, 32'd0,        32'd0,        0,  1,  0, 32'hBADFABAC, 2'd1, 32'h30000000};
        vecs[3]  = '{32'hF0000010, 1, 1, 0, -1, -1, 32'd0,        32'd0,        1,  9,  0, 32'hBADFABAC, 2'd2, 32'hF0000010};
        vecs[4]  = '{32'hF0000044, 1, 0, 0, -1, -1, 32'd0,        32'd0,        1,  9,  0, 32'hBADFABAC, 2'd2, 32'hF0000010};
        vecs[5]  = '{32'h90000020, 1, 1, 1,  8, -1, 32'd0,        32'h12345678, 2,  9,  1, 32'h12345678, 2'd0, 32'h0};
        vecs[6]  = '{32'h90000030, 1, 1, 1,  4,  4, 32'd0,        32'hCAFEF00D, 2,  5,  0, 32'hBADFABAC, 2'd3, 32'h90000030};
        vecs[7]  = '{32'hF0001000, 0, 1, 0,  1, -1, 32'hA5A5A5A5, 32'd0,        1,  2,  1, 32'hA5A5A5A5, 2'd0, 32'h0};
        vecs[8]  = '{32'h9ABCDEF0, 0, 1, 1, -1,  2, 32'd0,        32'd0,        2,  3,  0, 32'hBADFABAC, 2'd3, 32'h9ABCDEF0};
        vecs[9]  = '{32'hE0000000, 0, 1, 0, -1, -1, 32'd0,        32'd0,        0,  1,  0, 32'hBADFABAC, 2'd1, 32'hE0000000};
        vecs[10] = '{32'h80000000, 0, 0, 0, -1, -1, 32'd0,        32'd0,        0,  1,  0, 32'hBADFABAC, 2'd1, 32'hE0000000};
        vecs[11] = '{32'hF0000008, 1, 1, 1,  2, -1, 32'd0,        32'h11111111, 1,  9,  0, 32'hBADFABAC, 2'd2, 32'hF0000008};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst ack", {31'd0, a_ack}, 32'd0);
        chk("rst err", {31'd0, a_err}, 32'd0);
        chk("rst dat", a_dat, 32'd0);
        chk("rst stb", {30'd0, a_s0, a_s1}, 32'd0);
        chk("rst log", {a_eadr[29:0], a_ec}, 32'd0);
        rstn_i = 1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
            repeat (2) tick();
        end

        // Master abandons the cycle in BUSY while the slave acks: no response.
        sel = 0; m_adr_i = 32'hF0000100; s0_dat_i = 32'h0000FFFF;
        set_cyc(1'b1);
        tick(); tick();
        set_cyc(1'b0);
        s0_ack_i = 1;
        tick();
        s0_ack_i = 0;
        nr = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (a_ack || a_err) nr++;
            tick();
        end
        chk("cyc_drop no_resp", nr, 0);

        // Sticky log, then a clear that coincides with a new error.
        err_clr_i = 1; tick(); err_clr_i = 0;
        m_adr_i = 32'h60000000; set_cyc(1'b1);
        tick();
        set_cyc(1'b0);
        chk("unmapped err", {31'd0, a_err}, 32'd1);
        tick();
        chk("log first adr", a_eadr, LOG ? 32'h60000000 : 32'd0);
        m_adr_i = 32'h50000000; set_cyc(1'b1); err_clr_i = 1;
        tick();
        set_cyc(1'b0); err_clr_i = 0;
        chk("clr+err cause", {30'd0, a_ec}, LOG ? 32'd1 : 32'd0);
        chk("clr+err adr", a_eadr, LOG ? 32'h50000000 : 32'd0);
        tick();
        err_clr_i = 1; tick(); err_clr_i = 0;
        chk("clr cause", {30'd0, a_ec}, 32'd0);
        chk("clr adr", a_eadr, 32'd0);

        // Asynchronous reset in the middle of a BUSY cycle.
        m_adr_i = 32'h70000000; set_cyc(1'b1);
        tick();
        set_cyc(1'b0);
        tick();
        m_adr_i = 32'hF0000200; set_cyc(1'b1);
        tick(); tick();
        chk("busy s0_stb", {31'd0, a_s0}, 32'd1);
        #2 rstn_i = 0;
        #1;
        chk("midrst stb", {30'd0, a_s0, a_s1}, 32'd0);
        chk("midrst dat", a_dat, 32'd0);
        chk("midrst resp", {30'd0, a_ack, a_err}, 32'd0);
        chk("midrst log", {a_eadr[29:0], a_ec}, 32'd0);
        set_cyc(1'b0);
        tick();
        rstn_i = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
